// File: rtl/piso_frame_tx.sv
// Parallel-in/serial-out frame transmitter: start bit, data MSB-first,
// optional parity bit, stop bit. Feeds the serial input of a downstream shift register.
module piso_frame_tx #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned PARITY_EN  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             frame_done
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic PAR_INV = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] buf_q, buf_d;
  logic             par_q, par_d;
  // Holds off din_ready until the first edge with reset_n sampled high.
  logic             rdy_en_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      buf_q    <= '0;
      par_q    <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      buf_q    <= buf_d;
      par_q    <= par_d;
      rdy_en_q <= 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    buf_d      = buf_q;
    par_d      = par_q;
    sout       = 1'b1;
    sout_valid = 1'b0;
    busy       = 1'b1;
    frame_done = 1'b0;
    din_ready  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        busy      = 1'b0;
        din_ready = rdy_en_q;
        if (din_valid && rdy_en_q) begin
          buf_d   = din;
          par_d   = (^din) ^ PAR_INV;
          cnt_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        sout    = 1'b0;
        cnt_d   = '0;
        state_d = S_DATA;
      end
      S_DATA: begin
        sout       = buf_q[WIDTH-1];
        sout_valid = 1'b1;
        buf_d      = {buf_q[WIDTH-2:0], 1'b0};
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_PARITY: begin
        sout    = par_q;
        state_d = S_STOP;
      end
      S_STOP: begin
        frame_done = 1'b1;
        din_ready  = rdy_en_q;
        // An accept here chains the next frame with no idle gap.
        if (din_valid && rdy_en_q) begin
          buf_d   = din;
          par_d   = (^din) ^ PAR_INV;
          cnt_d   = '0;
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_piso_frame_tx.sv
// Bench for piso_frame_tx: three parameter variants, scoreboard queues of
// per-cycle expected outputs, table-driven frames plus handshake/reset sequences.
module tb_piso_frame_tx;

  typedef struct packed {
    logic sout;
    logic sv;
    logic fd;
    logic rdy;
    logic busy;
  } exp_t;

  typedef struct {
    int         k;
    logic [3:0] w;
    logic [7:0] bits;
    int         len;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] din = 4'b0000;
  logic [2:0] valid = 3'b000;
  logic [2:0] rdy_w, sout_w, sv_w, busy_w, fd_w;
  logic [3:0] sr = 4'b0000;
  logic       mon_en = 1'b0;
  int         total = 0;
  int         bad = 0;
  exp_t       q0[$];
  exp_t       q1[$];
  exp_t       q2[$];
  vec_t       vecs[8];

  always #5 clk = ~clk;

  piso_frame_tx #(.WIDTH(4), .PARITY_EN(1), .PARITY_ODD(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .din(din), .din_valid(valid[0]),
    .din_ready(rdy_w[0]), .sout(sout_w[0]), .sout_valid(sv_w[0]),
    .busy(busy_w[0]), .frame_done(fd_w[0])
  );
  piso_frame_tx #(.WIDTH(4), .PARITY_EN(1), .PARITY_ODD(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .din(din), .din_valid(valid[1]),
    .din_ready(rdy_w[1]), .sout(sout_w[1]), .sout_valid(sv_w[1]),
    .busy(busy_w[1]), .frame_done(fd_w[1])
  );
  piso_frame_tx #(.WIDTH(4), .PARITY_EN(0), .PARITY_ODD(0)) dut2 (
    .clk(clk), .reset_n(reset_n), .din(din), .din_valid(valid[2]),
    .din_ready(rdy_w[2]), .sout(sout_w[2]), .sout_valid(sv_w[2]),
    .busy(busy_w[2]), .frame_done(fd_w[2])
  );

  // Downstream 4-bit shift register fed by the default instance.
  always @(posedge clk) begin
    if (sv_w[0] === 1'b1) sr <= {sr[2:0], sout_w[0]};
  end

  task automatic check(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%b required=%b t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic check4(input string nm, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%b required=%b t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int qsize(input int k);
    case (k)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic push(input int k, input logic [7:0] bits, input int len);
    exp_t e;
    for (int i = 0; i < len; i++) begin
      e.sout = bits[len-1-i];
      e.sv   = (i >= 1 && i <= 4);
      e.fd   = (i == len - 1);
      e.rdy  = (i == len - 1);
      e.busy = 1'b1;
      case (k)
        0: q0.push_back(e);
        1: q1.push_back(e);
        default: q2.push_back(e);
      endcase
    end
  endtask

  task automatic mon(input int k);
    exp_t e;
    logic have;
    have = 1'b0;
    e = '{sout: 1'b1, sv: 1'b0, fd: 1'b0, rdy: 1'b0, busy: 1'b0};
    case (k)
      0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
    endcase
    $display("cycle t=%0t dut%0d sout=%b sv=%b busy=%b fd=%b rdy=%b", $time, k,
             sout_w[k], sv_w[k], busy_w[k], fd_w[k], rdy_w[k]);
    check($sformatf("dut%0d sout", k), sout_w[k], e.sout);
    check($sformatf("dut%0d sout_valid", k), sv_w[k], e.sv);
    check($sformatf("dut%0d busy", k), busy_w[k], e.busy);
    check($sformatf("dut%0d frame_done", k), fd_w[k], e.fd);
    if (have) check($sformatf("dut%0d din_ready", k), rdy_w[k], e.rdy);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      for (int k = 0; k < 3; k++) mon(k);
    end
  end

  // Present a word and wait (bounded) for the accept edge; expected cycles are
  // queued right after that edge so the monitor sees them from the START cycle.
  task automatic send(input int k, input logic [3:0] w, input logic [7:0] bits, input int len);
    logic r;
    logic done;
    done = 1'b0;
    @(negedge clk);
    din = w;
    valid[k] = 1'b1;
    for (int c = 0; c < 40 && !done; c++) begin
      if (c > 0) @(negedge clk);
      r = rdy_w[k];
      @(posedge clk);
      #1;
      if (r === 1'b1) begin
        push(k, bits, len);
        done = 1'b1;
      end
    end
    valid[k] = 1'b0;
    total++;
    if (!done) begin
      bad++;
      $display("FAIL dut%0d accept actual=timeout required=accepted", k);
    end
  endtask

  task automatic wait_idle(input int k);
    int c;
    c = 0;
    while (qsize(k) > 0 && c < 40) begin
      @(negedge clk);
      c++;
    end
    @(posedge clk);
    #1;
    total++;
    if (qsize(k) != 0) begin
      bad++;
      $display("FAIL dut%0d drain actual=%0d required=0", k, qsize(k));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{k: 0, w: 4'b1101, bits: 8'b0_0110111, len: 7};
    vecs[1] = '{k: 0, w: 4'b0001, bits: 8'b0_0000111, len: 7};
    vecs[2] = '{k: 0, w: 4'b1111, bits: 8'b0_0111101, len: 7};
    vecs[3] = '{k: 0, w: 4'b0000, bits: 8'b0_0000001, len: 7};
    vecs[4] = '{k: 1, w: 4'b1101, bits: 8'b0_0110101, len: 7};
    vecs[5] = '{k: 1, w: 4'b0000, bits: 8'b0_0000011, len: 7};
    vecs[6] = '{k: 2, w: 4'b1101, bits: 8'b00_011011, len: 6};
    vecs[7] = '{k: 2, w: 4'b0010, bits: 8'b00_000101, len: 6};

    // Reset held for two edges, then released.
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) check($sformatf("dut%0d din_ready in reset", k), rdy_w[k], 1'b0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) check($sformatf("dut%0d din_ready after release", k), rdy_w[k], 1'b1);

    for (int i = 0; i < 8; i++) begin
      send(vecs[i].k, vecs[i].w, vecs[i].bits, vecs[i].len);
      wait_idle(vecs[i].k);
      if (vecs[i].k == 0) check4("shift_reg q", sr, vecs[i].w);
    end

    // Back-to-back: second word held valid until the STOP-cycle accept.
    send(0, 4'b0001, 8'b0_0000111, 7);
    send(0, 4'b1111, 8'b0_0111101, 7);
    wait_idle(0);
    check4("shift_reg q b2b", sr, 4'b1111);

    // din changed mid-frame with valid high: in-flight frame unaffected.
    send(0, 4'b1101, 8'b0_0110111, 7);
    repeat (2) @(negedge clk);
    send(0, 4'b0110, 8'b0_0011001, 7);
    wait_idle(0);
    check4("shift_reg q midchange", sr, 4'b0110);

    // Reset during the third DATA bit abandons the frame.
    send(0, 4'b1101, 8'b0_0110111, 7);
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    q0.delete();
    reset_n = 1'b1;
    check("reset mid sout", sout_w[0], 1'b1);
    check("reset mid busy", busy_w[0], 1'b0);
    check("reset mid sout_valid", sv_w[0], 1'b0);
    check("reset mid frame_done", fd_w[0], 1'b0);
    check("reset mid din_ready", rdy_w[0], 1'b0);
    send(0, 4'b1010, 8'b0_0101001, 7);
    wait_idle(0);
    check4("shift_reg q after reset", sr, 4'b1010);

    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
